soc_system_sysid_checker: RTL and testbench



---
 rtl/soc_system_sysid_checker.sv | 152 +++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM master: reads sysid words (ID @0, timestamp @1) and checks them against expected values.
// Optional build macro SYSID_CHECKER_AUTOSTART_EN: launch one check automatically after every reset.
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5616570D,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [15:0] stall_cnt;
  logic        launch;
  logic        reading;
  logic        stall_expired;

`ifdef SYSID_CHECKER_AUTOSTART_EN
  // High only in the first cycle after reset releases: acts as one internal start pulse.
  logic auto_pending;

  always_ff @(posedge clock) begin
    if (reset) auto_pending <= 1'b1;
    else       auto_pending <= 1'b0;
  end

  assign launch = start | auto_pending;
`else
  assign launch = start;
`endif

  // Handshake: avm_read is the valid, ~avm_waitrequest the ready; a read completes in the
  // cycle both hold, and avm_read/avm_address stay put until it does (or the stall times out).
  assign reading       = (state == RD_ID) || (state == RD_TS);
  assign stall_expired = avm_waitrequest && (stall_cnt == TO_LIM);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (launch) state_next = RD_ID;
      end
      RD_ID: begin
        avm_read = 1'b1;
        if (!avm_waitrequest)   state_next = RD_TS;
        else if (stall_expired) state_next = FINISH;
      end
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest || stall_expired) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      read_id   <= '0;
      read_ts   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            stall_cnt <= '0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            read_id   <= '0;
            read_ts   <= '0;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            read_id   <= avm_readdata;
            id_ok     <= (avm_readdata == EXPECTED_ID);
            stall_cnt <= '0;
          end else if (stall_expired) begin
            timeout <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        RD_TS: begin
          // pass is settled on the way into FINISH so it is valid alongside done.
          if (!avm_waitrequest) begin
            read_ts <= avm_readdata;
            ts_ok   <= (avm_readdata == EXPECTED_TIMESTAMP);
            pass    <= id_ok && (avm_readdata == EXPECTED_TIMESTAMP) && !timeout;
          end else if (stall_expired) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // reading is kept for readability of the handshake; it mirrors avm_read.
  logic unused_ok;
  assign unused_ok = reading;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for soc_system_sysid_checker with a scripted sysid slave and a timeline model.
module tb_soc_system_sysid_checker;

  localparam int          TO     = 8;
  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h5616570D;
  localparam int          W      = 68;   // {timeout, id_ok, ts_ok, pass, read_id, read_ts}

  // clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        busy, done, id_ok, ts_ok, pass, timeout;
  logic [31:0] read_id, read_ts;
  logic [1:0]  state_dbg;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  soc_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .pass(pass),
    .timeout(timeout), .read_id(read_id), .read_ts(read_ts), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // scripted slave: stalls each address for a set number of cycles, then returns its word
  logic [31:0] sl_id = EXP_ID;
  logic [31:0] sl_ts = EXP_TS;
  int sl_id_st = 0, sl_ts_st = 0, sl_cnt0 = 0, sl_cnt1 = 0;

  always @(negedge clock) begin
    if (avm_read === 1'b1) begin
      if (avm_address === 1'b0) begin
        if (sl_cnt0 < sl_id_st) begin
          avm_waitrequest = 1'b1; avm_readdata = 32'hBAD0BAD0; sl_cnt0++;
        end else begin
          avm_waitrequest = 1'b0; avm_readdata = sl_id;
        end
      end else begin
        if (sl_cnt1 < sl_ts_st) begin
          avm_waitrequest = 1'b1; avm_readdata = 32'hBAD1BAD1; sl_cnt1++;
        end else begin
          avm_waitrequest = 1'b0; avm_readdata = sl_ts;
        end
      end
    end else begin
      sl_cnt0 = 0; sl_cnt1 = 0;
      avm_waitrequest = 1'b0; avm_readdata = '0;
    end
  end

  // model: a check launched with start seen in cycle s occupies cycles s+1 .. m_done
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_held = '0;
  bit           m_active = 1'b0;
  bit           chk_en = 1'b0;
  int           m_s = 0, m_done = 0, m_id_st = 0;
  int           last_done_cyc = -1;

  task automatic model_launch(input int s);
    logic [W-1:0] r;
    r        = '0;
    m_active = 1'b1;
    m_s      = s;
    m_id_st  = sl_id_st;
    if (sl_id_st > TO) begin
      m_done = s + 2 + TO;
      r[67]  = 1'b1;
    end else begin
      r[63:32] = sl_id;
      r[66]    = (sl_id == EXP_ID);
      if (sl_ts_st > TO) begin
        m_done = s + 3 + sl_id_st + TO;
        r[67]  = 1'b1;
      end else begin
        m_done  = s + 3 + sl_id_st + sl_ts_st;
        r[31:0] = sl_ts;
        r[65]   = (sl_ts == EXP_TS);
        r[64]   = r[66] & r[65];
      end
    end
    exp_q.push_back(r);
  endtask

  // scoreboard / compare process
  logic e_busy, e_done, e_read;
  always @(negedge clock) begin
    if (chk_en) begin
      e_busy = m_active && (cyc >= m_s + 1) && (cyc <= m_done);
      e_done = m_active && (cyc == m_done);
      e_read = e_busy && !e_done;
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("avm_read", avm_read, e_read);
      check("state_busy", state_dbg != 2'd0, e_busy);
      if (e_read) check("avm_address", avm_address, (cyc >= m_s + 2 + m_id_st) ? 1 : 0);
      if (done === 1'b1) last_done_cyc = cyc;
      if (e_done) begin
        if (exp_q.size() > 0) m_held = exp_q.pop_front();
        m_active = 1'b0;
      end
      if (!e_busy || e_done) begin
        check("timeout", timeout, m_held[67]);
        check("id_ok", id_ok, m_held[66]);
        check("ts_ok", ts_ok, m_held[65]);
        check("pass", pass, m_held[64]);
        check("read_id", read_id, m_held[63:32]);
        check("read_ts", read_ts, m_held[31:0]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_active && guard < 300) begin
      step();
      guard++;
    end
    if (m_active) begin
      total++;
      bad++;
      $display("FAIL wait_done: got busy after %0d cycles expected done", guard);
      m_active = 1'b0;
      exp_q.delete();
    end
    step();
  endtask

  task automatic release_reset();
    reset = 1'b0;
`ifdef SYSID_CHECKER_AUTOSTART_EN
    model_launch(cyc);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    m_active = 1'b0;
    exp_q.delete();
    m_held = '0;
    release_reset();
    wait_idle();
  endtask

  task automatic run_check(input logic [31:0] id_w, input logic [31:0] ts_w,
                           input int id_st, input int ts_st, input bit poke,
                           output int s_out);
    sl_id = id_w; sl_ts = ts_w; sl_id_st = id_st; sl_ts_st = ts_st;
    start = 1'b1;
    s_out = cyc;
    model_launch(cyc);
    step(); start = poke;
    step(); start = 1'b0;
    step(); start = poke;
    step(); start = 1'b0;
    wait_idle();
  endtask

  int t_s;

  initial begin
    step();
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read_id", read_id, 0);
    m_held = '0;
    chk_en = 1'b1;
    release_reset();
    wait_idle();
    repeat (10) step();
`ifdef SYSID_CHECKER_AUTOSTART_EN
    check("autostart_done_cyc", last_done_cyc, 4);
`else
    check("no_autostart", last_done_cyc, 32'hFFFFFFFF);
`endif

    run_check(EXP_ID, EXP_TS, 0, 0, 1'b0, t_s);
    check("t1_latency", last_done_cyc - t_s, 3);
    check("t1_read_id", read_id, 32'hACD51302);
    check("t1_pass", pass, 1);

    run_check(EXP_ID, 32'h5616570E, 0, 0, 1'b0, t_s);
    check("t2_read_ts", read_ts, 32'h5616570E);
    check("t2_ts_ok", ts_ok, 0);
    check("t2_id_ok", id_ok, 1);

    run_check(32'hACD51303, EXP_TS, 1, 2, 1'b0, t_s);
    run_check(EXP_ID, EXP_TS, 4, 4, 1'b0, t_s);
    check("t4_latency", last_done_cyc - t_s, 11);
    check("t4_pass", pass, 1);

    run_check(EXP_ID, EXP_TS, 1000, 0, 1'b0, t_s);
    check("t5_latency", last_done_cyc - t_s, 10);
    check("t5_timeout", timeout, 1);
    check("t5_read_id", read_id, 0);
    check("t5_avm_read", avm_read, 0);

    run_check(EXP_ID, EXP_TS, 2, 1000, 1'b0, t_s);
    run_check(EXP_ID, EXP_TS, TO, 0, 1'b0, t_s);
    check("t7_latency", last_done_cyc - t_s, 11);
    check("t7_timeout", timeout, 0);

    run_check(EXP_ID, 32'h00000000, 0, 0, 1'b1, t_s);
    repeat (4) step();

    // reset while reading the timestamp
    sl_id = EXP_ID; sl_ts = EXP_TS; sl_id_st = 0; sl_ts_st = 0;
    start = 1'b1;
    model_launch(cyc);
    step(); start = 1'b0;
    step();
    do_reset();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
